// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller.
// Holds the CSR addresses, exception and interrupt codes, the FSM encoding and the mtvec modes.
// Also holds the trap-update bundle and the redirect-target helper.
package trap_pkg;

   // Trap CSR addresses
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   // Synchronous exception codes
   localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
   localparam logic [3:0] EXC_INSTR_FAULT      = 4'd1;
   localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
   localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
   localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
   localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
   localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;
   localparam logic [3:0] EXC_ECALL_U          = 4'd8;
   localparam logic [3:0] EXC_ECALL_S          = 4'd9;
   localparam logic [3:0] EXC_RESERVED_10      = 4'd10;
   localparam logic [3:0] EXC_ECALL_M          = 4'd11;

   // Machine interrupt codes
   localparam logic [3:0] IRQ_MSI = 4'd3;
   localparam logic [3:0] IRQ_MTI = 4'd7;
   localparam logic [3:0] IRQ_MEI = 4'd11;

   // mtvec mode field (bit 0)
   localparam logic MTVEC_DIRECT   = 1'b0;
   localparam logic MTVEC_VECTORED = 1'b1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_ENTER = 2'b01,
      ST_EXIT  = 2'b10
   } state_t;

   // Values written into mepc/mcause/mtval when a trap is accepted
   typedef struct packed {
      logic [29:0] epc;     // word-aligned PC, bits [31:2]
      logic [31:0] cause;
      logic [31:0] tval;
   } trap_upd_t;

   // Trap vector: the base, plus 4*code for interrupts in vectored mode (wraps mod 2^32)
   function automatic logic [31:0] trap_target(input logic [29:0] base,
                                               input logic        mode,
                                               input logic        is_irq,
                                               input logic [3:0]  code);
      logic [31:0] b;
      b = {base, 2'b00};
      if (is_irq && (mode == MTVEC_VECTORED))
         return b + {26'd0, code, 2'b00};
      return b;
   endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Trap controller bus: pipeline trap requests, interrupt levels, CSR access port, redirect outputs.
// master = pipeline / machine-status side, slave = trap_ctrl.
// No flow control on this bus; the pipeline must hold its requests while busy is high.
interface trap_ctrl_if;
   logic        exc_req;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        mret_req;
   logic [31:0] irq_pc;
   logic        irq_pc_valid;
   logic        mstatus_mie;
   logic        meip;
   logic        mtip;
   logic        msip;
   logic [11:0] csr_addr;
   logic        csr_we;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        exception_raised;
   logic        is_mret;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        busy;

   modport master (
      output exc_req, exc_cause, exc_pc, exc_tval, mret_req,
      output irq_pc, irq_pc_valid, mstatus_mie, meip, mtip, msip,
      output csr_addr, csr_we, csr_wdata,
      input  csr_rdata, exception_raised, is_mret, redirect, redirect_pc, busy
   );

   modport slave (
      input  exc_req, exc_cause, exc_pc, exc_tval, mret_req,
      input  irq_pc, irq_pc_valid, mstatus_mie, meip, mtip, msip,
      input  csr_addr, csr_we, csr_wdata,
      output csr_rdata, exception_raised, is_mret, redirect, redirect_pc, busy
   );
endinterface

// File: rtl/trap_csr_file.sv
// Trap CSR storage (mtvec, mie, mscratch, mepc, mcause, mtval) plus a read-only mip view.
// Latency: writes land at the next rising edge; reads are combinational and return pre-edge values.
// Ports: CSR read/write port, interrupt levels, trap update, and decoded mtvec/mie/mip/mepc fields.
module trap_csr_file
   import trap_pkg::*;
#(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] csr_addr,
   input  logic        csr_we,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   input  logic        meip,
   input  logic        mtip,
   input  logic        msip,
   input  logic        trap_we,
   input  trap_upd_t   trap_upd,
   output logic [29:0] mtvec_base,
   output logic        mtvec_mode,
   output logic [2:0]  mie_bits,      // {MEIE, MTIE, MSIE}
   output logic [2:0]  mip_bits,      // {MEIP, MTIP, MSIP}
   output logic [29:0] mepc_word
);

   logic [31:0] mscratch_q;
   logic [31:0] mcause_q;
   logic [31:0] mtval_q;

   assign mip_bits = {meip, mtip, msip};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtvec_base <= RESET_MTVEC[31:2];
         mtvec_mode <= RESET_MTVEC[0];
         mie_bits   <= 3'b000;
         mscratch_q <= 32'd0;
         mepc_word  <= 30'd0;
         mcause_q   <= 32'd0;
         mtval_q    <= 32'd0;
      end else begin
         if (csr_we) begin
            case (csr_addr)
               CSR_MTVEC: begin
                  mtvec_base <= csr_wdata[31:2];
                  mtvec_mode <= csr_wdata[0];
               end
               CSR_MIE:      mie_bits   <= {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
               CSR_MSCRATCH: mscratch_q <= csr_wdata;
               CSR_MEPC:     mepc_word  <= csr_wdata[31:2];
               CSR_MCAUSE:   mcause_q   <= csr_wdata;
               CSR_MTVAL:    mtval_q    <= csr_wdata;
               default: ;
            endcase
         end
         // Placed after the CSR write so a trap accepted on the same edge overrides it
         if (trap_we) begin
            mepc_word <= trap_upd.epc;
            mcause_q  <= trap_upd.cause;
            mtval_q   <= trap_upd.tval;
         end
      end
   end

   always_comb begin
      csr_rdata = 32'd0;
      case (csr_addr)
         CSR_MTVEC:    csr_rdata = {mtvec_base, 1'b0, mtvec_mode};
         CSR_MIE:      csr_rdata = {20'd0, mie_bits[2], 3'd0, mie_bits[1], 3'd0, mie_bits[0], 3'd0};
         CSR_MIP:      csr_rdata = {20'd0, mip_bits[2], 3'd0, mip_bits[1], 3'd0, mip_bits[0], 3'd0};
         CSR_MSCRATCH: csr_rdata = mscratch_q;
         CSR_MEPC:     csr_rdata = {mepc_word, 2'b00};
         CSR_MCAUSE:   csr_rdata = mcause_q;
         CSR_MTVAL:    csr_rdata = mtval_q;
         default:      csr_rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exception > interrupt > mret and redirects fetch.
// Latency: request sampled at edge N, registered strobes/redirect high for the single cycle N..N+1.
// Backpressure: busy is high outside RUN; requests presented then are dropped, not queued.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   trap_ctrl_if.slave   bus
);

   state_t      state;
   logic        exc_raised_q;
   logic        is_mret_q;
   logic        redirect_q;
   logic        busy_q;
   logic [31:0] redirect_pc_q;

   logic [29:0] mtvec_base;
   logic        mtvec_mode;
   logic [2:0]  mie_bits;
   logic [2:0]  mip_bits;
   logic [29:0] mepc_word;

   logic        take_exc;
   logic        take_irq;
   logic        take_mret;
   logic [2:0]  irq_pend;
   logic [3:0]  irq_code;
   trap_upd_t   trap_upd;

   // PCs are stored word-aligned, so their low bits are never consulted
   logic        unused_pc_bits;
   assign unused_pc_bits = ^{bus.exc_pc[1:0], bus.irq_pc[1:0]};

   assign irq_pend = mip_bits & mie_bits;

   // Interrupt priority: MEI, then MSI, then MTI
   always_comb begin
      irq_code = IRQ_MTI;
      if (irq_pend[2])
         irq_code = IRQ_MEI;
      else if (irq_pend[0])
         irq_code = IRQ_MSI;
   end

   assign take_exc  = (state == ST_RUN) && bus.exc_req;
   assign take_irq  = (state == ST_RUN) && !bus.exc_req &&
                      bus.mstatus_mie && bus.irq_pc_valid && (|irq_pend);
   assign take_mret = (state == ST_RUN) && !bus.exc_req && !take_irq && bus.mret_req;

   always_comb begin
      trap_upd.epc   = take_exc ? bus.exc_pc[31:2] : bus.irq_pc[31:2];
      trap_upd.cause = take_exc ? {28'd0, bus.exc_cause} : {1'b1, 27'd0, irq_code};
      trap_upd.tval  = take_exc ? bus.exc_tval : 32'd0;
   end

   trap_csr_file #(
      .RESET_MTVEC (RESET_MTVEC)
   ) u_csr (
      .clk        (clk),
      .rst        (rst),
      .csr_addr   (bus.csr_addr),
      .csr_we     (bus.csr_we),
      .csr_wdata  (bus.csr_wdata),
      .csr_rdata  (bus.csr_rdata),
      .meip       (bus.meip),
      .mtip       (bus.mtip),
      .msip       (bus.msip),
      .trap_we    (take_exc || take_irq),
      .trap_upd   (trap_upd),
      .mtvec_base (mtvec_base),
      .mtvec_mode (mtvec_mode),
      .mie_bits   (mie_bits),
      .mip_bits   (mip_bits),
      .mepc_word  (mepc_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_RUN;
         exc_raised_q  <= 1'b0;
         is_mret_q     <= 1'b0;
         redirect_q    <= 1'b0;
         busy_q        <= 1'b0;
         redirect_pc_q <= 32'd0;
      end else begin
         case (state)
            ST_RUN: begin
               if (take_exc || take_irq) begin
                  state         <= ST_ENTER;
                  exc_raised_q  <= 1'b1;
                  redirect_q    <= 1'b1;
                  busy_q        <= 1'b1;
                  redirect_pc_q <= trap_target(mtvec_base, mtvec_mode, take_irq, irq_code);
               end else if (take_mret) begin
                  state         <= ST_EXIT;
                  is_mret_q     <= 1'b1;
                  redirect_q    <= 1'b1;
                  busy_q        <= 1'b1;
                  redirect_pc_q <= {mepc_word, 2'b00};
               end
            end
            default: begin
               // ENTER/EXIT last one cycle; the redirect target is simply held
               state        <= ST_RUN;
               exc_raised_q <= 1'b0;
               is_mret_q    <= 1'b0;
               redirect_q   <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.exception_raised = exc_raised_q;
   assign bus.is_mret          = is_mret_q;
   assign bus.redirect         = redirect_q;
   assign bus.redirect_pc      = redirect_pc_q;
   assign bus.busy             = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: CSR read-backs against constants, plus a redirect scoreboard.
// Each trap/mret request pushes its expected strobe/target; the negedge monitor pops on redirect.
// Ports: drives every trap_ctrl_if signal, clk and rst.
module tb_trap_ctrl;
   import trap_pkg::*;

   typedef struct packed {
      logic        raised;
      logic        mret;
      logic [31:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t e;

   trap_ctrl_if bus();

   trap_ctrl #(.RESET_MTVEC(32'h0000_0100)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: every redirect must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && bus.redirect === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_redirect", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_exception_raised", {31'd0, bus.exception_raised}, {31'd0, e.raised});
            chk("sb_is_mret", {31'd0, bus.is_mret}, {31'd0, e.mret});
            chk("sb_busy", {31'd0, bus.busy}, 32'd1);
            chk("sb_redirect_pc", bus.redirect_pc, e.pc);
         end
      end
   end

   task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.csr_addr  = addr;
      bus.csr_wdata = data;
      bus.csr_we    = 1'b1;
      @(negedge clk);
      bus.csr_we    = 1'b0;
   endtask

   task automatic csr_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      @(negedge clk);
      bus.csr_addr = addr;
      #1;
      chk(tag, bus.csr_rdata, exp);
   endtask

   // Request already driven: the strobe must be visible one edge later
   task automatic expect_pulse(input string tag);
      @(negedge clk);
      #1;
      chk({tag, "_latency"}, {31'd0, bus.redirect}, 32'd1);
   endtask

   // Strobes must be gone the following cycle and the scoreboard drained
   task automatic expect_idle(input string tag);
      @(negedge clk);
      #1;
      chk({tag, "_idle"}, {28'd0, bus.exception_raised, bus.is_mret, bus.redirect, bus.busy}, 32'd0);
      chk({tag, "_drained"}, sb.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, want finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.exc_req = 0; bus.exc_cause = 0; bus.exc_pc = 0; bus.exc_tval = 0;
      bus.mret_req = 0; bus.irq_pc = 0; bus.irq_pc_valid = 0; bus.mstatus_mie = 0;
      bus.meip = 0; bus.mtip = 0; bus.msip = 0;
      bus.csr_addr = 0; bus.csr_we = 0; bus.csr_wdata = 0;

      // ---- reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_strobes", {28'd0, bus.exception_raised, bus.is_mret, bus.redirect, bus.busy}, 32'd0);
      chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
      csr_rd("rst_mtvec",    CSR_MTVEC,    32'h0000_0100);
      csr_rd("rst_mie",      CSR_MIE,      32'd0);
      csr_rd("rst_mip",      CSR_MIP,      32'd0);
      csr_rd("rst_mscratch", CSR_MSCRATCH, 32'd0);
      csr_rd("rst_mepc",     CSR_MEPC,     32'd0);
      csr_rd("rst_mcause",   CSR_MCAUSE,   32'd0);
      csr_rd("rst_mtval",    CSR_MTVAL,    32'd0);

      // ---- CSR masking
      csr_wr(CSR_MTVEC, 32'h8000_0003);
      csr_rd("mtvec_bit1_masked", CSR_MTVEC, 32'h8000_0001);
      csr_wr(CSR_MIE, 32'hFFFF_FFFF);
      csr_rd("mie_masked", CSR_MIE, 32'h0000_0888);
      csr_wr(CSR_MIP, 32'hFFFF_FFFF);
      csr_rd("mip_write_ignored", CSR_MIP, 32'd0);
      csr_wr(CSR_MSCRATCH, 32'h1234_5678);
      csr_rd("mscratch_rw", CSR_MSCRATCH, 32'h1234_5678);
      csr_rd("unowned_reads_zero", 12'h300, 32'd0);

      // ---- direct-mode exception
      csr_wr(CSR_MTVEC, 32'h8000_0000);
      bus.exc_req = 1; bus.exc_cause = EXC_ILLEGAL_INSTR;
      bus.exc_pc = 32'h124; bus.exc_tval = 32'hDEAD_BEEF;
      sb.push_back('{raised: 1'b1, mret: 1'b0, pc: 32'h8000_0000});
      expect_pulse("exc");
      bus.exc_req = 0;
      expect_idle("exc");
      csr_rd("exc_mepc",   CSR_MEPC,   32'h124);
      csr_rd("exc_mcause", CSR_MCAUSE, 32'd2);
      csr_rd("exc_mtval",  CSR_MTVAL,  32'hDEAD_BEEF);

      // ---- vectored timer interrupt
      csr_wr(CSR_MTVEC, 32'h8000_0001);
      csr_wr(CSR_MIE, 32'h80);
      bus.mtip = 1;
      csr_rd("irq_mip", CSR_MIP, 32'h80);
      bus.irq_pc = 32'h200; bus.irq_pc_valid = 1; bus.mstatus_mie = 1;
      sb.push_back('{raised: 1'b1, mret: 1'b0, pc: 32'h8000_001C});
      expect_pulse("irq");
      bus.mstatus_mie = 0;
      expect_idle("irq");
      csr_rd("irq_mcause", CSR_MCAUSE, 32'h8000_0007);
      csr_rd("irq_mepc",   CSR_MEPC,   32'h200);
      csr_rd("irq_mtval",  CSR_MTVAL,  32'd0);
      bus.mtip = 0;

      // ---- mret
      csr_wr(CSR_MEPC, 32'h403);
      csr_rd("mepc_low_bits", CSR_MEPC, 32'h400);
      bus.mret_req = 1;
      sb.push_back('{raised: 1'b0, mret: 1'b1, pc: 32'h400});
      expect_pulse("mret");
      bus.mret_req = 0;
      expect_idle("mret");

      // ---- collision: exception + enabled MEI + mret + mcause write in one cycle
      csr_wr(CSR_MIE, 32'hFFFF_FFFF);
      @(negedge clk);
      bus.meip = 1; bus.mstatus_mie = 1; bus.irq_pc = 32'h600; bus.irq_pc_valid = 1;
      bus.mret_req = 1;
      bus.exc_req = 1; bus.exc_cause = EXC_ECALL_M; bus.exc_pc = 32'h302; bus.exc_tval = 32'h0000_0ABC;
      bus.csr_addr = CSR_MCAUSE; bus.csr_wdata = 32'h55; bus.csr_we = 1;
      sb.push_back('{raised: 1'b1, mret: 1'b0, pc: 32'h8000_0000});
      expect_pulse("coll");
      // Second exception presented during ENTER must be dropped
      bus.mret_req = 0; bus.mstatus_mie = 0; bus.csr_we = 0;
      bus.exc_cause = EXC_ILLEGAL_INSTR; bus.exc_pc = 32'h999; bus.exc_tval = 32'h1;
      expect_idle("coll_enter_req");
      bus.exc_req = 0;
      expect_idle("coll_after");
      csr_rd("coll_mcause", CSR_MCAUSE, 32'd11);
      csr_rd("coll_mepc",   CSR_MEPC,   32'h300);
      csr_rd("coll_mtval",  CSR_MTVAL,  32'h0000_0ABC);
      bus.meip = 0; bus.irq_pc_valid = 0;

      // ---- asynchronous reset during ENTER
      bus.exc_req = 1; bus.exc_cause = EXC_BREAKPOINT; bus.exc_pc = 32'h10; bus.exc_tval = 32'h7;
      sb.push_back('{raised: 1'b1, mret: 1'b0, pc: 32'h8000_0000});
      expect_pulse("rstenter");
      rst = 1'b1;
      #1;
      chk("rstenter_strobes", {28'd0, bus.exception_raised, bus.is_mret, bus.redirect, bus.busy}, 32'd0);
      chk("rstenter_redirect_pc", bus.redirect_pc, 32'd0);
      bus.exc_req = 0;
      @(negedge clk);
      rst = 1'b0;
      expect_idle("rstenter_release");
      csr_rd("rstenter_mtvec",  CSR_MTVEC,  32'h0000_0100);
      csr_rd("rstenter_mepc",   CSR_MEPC,   32'd0);
      csr_rd("rstenter_mcause", CSR_MCAUSE, 32'd0);
      csr_rd("rstenter_mtval",  CSR_MTVAL,  32'd0);
      csr_rd("rstenter_mie",    CSR_MIE,    32'd0);

      chk("sb_final_drain", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
